// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states and frame constants.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_WORD,
      ST_WRITE,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   // States in which the loader consumes bytes from the host stream.
   function automatic logic takes_bytes(input state_t s);
      return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_WORD) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a length-prefixed, checksummed byte stream into big-endian words,
// writes them to instruction memory and holds the CPU in reset until a good image is present.
import imem_loader_pkg::*;

module imem_loader #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        mem_wren,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   state_t      state;
   state_t      state_next;
   logic [15:0] len;
   logic [15:0] idx;
   logic [7:0]  sum;
   logic [1:0]  byte_cnt;
   logic        accept;
   logic        load_start;
   logic [15:0] len_full;

   assign accept   = byte_valid && byte_ready;
   assign len_full = {len[15:8], byte_data};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load_start = 1'b0;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               load_start = 1'b1;
               state_next = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (accept) state_next = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (accept) begin
               if (32'(len_full) > DEPTH_WORDS) state_next = ST_ERR;
               else if (len_full == 16'd0)      state_next = ST_CSUM;
               else                             state_next = ST_WORD;
            end
         end
         ST_WORD: begin
            if (accept && (byte_cnt == 2'(BYTES_PER_WORD - 1))) state_next = ST_WRITE;
         end
         ST_WRITE: begin
            state_next = ((idx + 16'd1) == len) ? ST_CSUM : ST_WORD;
         end
         ST_CSUM: begin
            if (accept) state_next = (byte_data == sum) ? ST_DONE : ST_ERR;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_ready <= 1'b0;
         mem_wren   <= 1'b0;
         mem_addr   <= BASE_ADDR;
         mem_wdata  <= 32'h0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         len        <= 16'h0;
         idx        <= 16'h0;
         sum        <= 8'h0;
         byte_cnt   <= 2'd0;
      end else begin
         byte_ready <= takes_bytes(state_next);
         mem_wren   <= (state_next == ST_WRITE);
         done       <= (state_next == ST_DONE);
         error      <= (state_next == ST_ERR);
         cpu_hold   <= (state_next != ST_DONE);
         if (load_start) begin
            sum      <= 8'h0;
            idx      <= 16'h0;
            byte_cnt <= 2'd0;
            mem_addr <= BASE_ADDR;
         end else begin
            if (accept) begin
               sum <= sum + byte_data;
               case (state)
                  ST_LEN_HI: len[15:8] <= byte_data;
                  ST_LEN_LO: len[7:0]  <= byte_data;
                  ST_WORD: begin
                     mem_wdata <= {mem_wdata[23:0], byte_data};
                     byte_cnt  <= byte_cnt + 2'd1;
                  end
                  default: ;
               endcase
            end
            // mem_addr already points at the word being written; advance it for the next one.
            if (state == ST_WRITE) begin
               idx      <= idx + 16'd1;
               mem_addr <= BASE_ADDR + {14'b0, idx + 16'd1, 2'b00};
            end
         end
      end
   end

endmodule
